zbus_master: RTL and testbench
==============================

ZBUS_MASTER -- requirements
Module: zbus_master

Interface
REQ-001 Parameter: TSTATE_CLKS, default 2, clk cycles per Z80 T-state (legal 1..15).
REQ-002 Parameter: WAIT_MAX, default 15, maximum wait T-states before abort (legal 1..255).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  cycle request.
REQ-006 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-007 req_io  in  1  1 = I/O cycle, 0 = memory cycle.
REQ-008 req_wr  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  16  bus address.
REQ-010 req_wdata  in  8  write data.
REQ-011 done  out  1  one-clock pulse at cycle end.
REQ-012 rdata  out  8  read data, valid from done until next done.
REQ-013 claimed  out  1  ziorqge sampled high during I/O cycle, valid with done.
REQ-014 timeout  out  1  cycle aborted on wait limit, valid with done.
REQ-015 za  out  16  address bus.
REQ-016 zd_out / zd_oe / zd_in  out/out/in  8/1/8  data bus, split tristate.
REQ-017 zmreq_n, ziorq_n, zrd_n, zwr_n  out  1 each  active-low strobes.
REQ-018 ziorqge  in  1  responder claim line.
REQ-019 zwait_n  in  1  responder wait request.

Function
REQ-020 FSM states: IDLE, ADDR, STRB, HOLD, DONE; each of ADDR/STRB/HOLD counts whole T-states of TSTATE_CLKS clocks.
REQ-021 req_ready SHALL be 1 only in IDLE; on acceptance, req fields SHALL be latched, za driven from the next clock.
REQ-022 ADDR: 1 T-state, address valid, all strobes high, zd_oe = req_wr.
REQ-023 STRB: zmreq_n or ziorq_n low (per req_io) together with zrd_n or zwr_n low (per req_wr); length 2 T-states for memory, 3 for I/O (built-in TW).
REQ-024 Read data and ziorqge SHALL be sampled on the last clock of STRB into rdata/claimed.
REQ-025 HOLD: 1 T-state, strobes high, za and zd_oe unchanged; then DONE for exactly 1 clock (done=1), then IDLE.
REQ-026 Total latency acceptance->done: (ADDR+STRB+HOLD)*TSTATE_CLKS+1 clocks; memory TSTATE_CLKS=2 -> 9 clocks, I/O -> 11 clocks.
REQ-027 Back-to-back: req_ready SHALL re-assert the clock after done; a request held valid SHALL be accepted then.
REQ-028 zd_oe SHALL be 0 for reads and in IDLE; zd_out holds latched write data.
REQ-029 claimed SHALL be 0 for memory cycles; rdata unchanged on writes.
REQ-030 Request inputs are ignored outside acceptance; changes mid-cycle SHALL have no effect.

Reset
REQ-031 rst SHALL force IDLE on the next edge, aborting any cycle without done.
REQ-032 Reset values: req_ready=1 (first clock after reset release), done=0, rdata=0, claimed=0, timeout=0, za=0, zd_out=0, zd_oe=0, all strobes=1.
REQ-033 Strobes SHALL never glitch low during or immediately after reset.

Configuration
REQ-034 Macro ZBUS_MASTER_WAIT_EN: when defined, zwait_n is sampled on the last clock of each STRB T-state from the second onward; low extends STRB by one T-state, repeatedly.
REQ-035 With ZBUS_MASTER_WAIT_EN, exceeding WAIT_MAX inserted T-states SHALL end STRB, go to HOLD, report timeout=1 with done, and set rdata=8'hFF.
REQ-036 Without ZBUS_MASTER_WAIT_EN, zwait_n SHALL be ignored and timeout SHALL stay 0.

Structure
REQ-037 Shared package zbus_pkg: FSM state enum, T-state counts (MEM_STRB_T=2, IO_STRB_T=3), timeout read value 8'hFF.
REQ-038 One sub-module zbus_tcnt: T-state prescaler producing the per-T-state tick.

Verification
REQ-039 Memory read 16'h4000, zd_in=8'h5A, TSTATE_CLKS=2 -> zmreq_n/zrd_n low 4 clocks, done at clock 9, rdata=8'h5A, claimed=0.
REQ-040 I/O write 16'h80AB data 8'h3C, ziorqge=1 -> ziorq_n/zwr_n low 6 clocks, zd_oe=1 ADDR..HOLD, claimed=1.
REQ-041 Two requests back-to-back held valid -> second accepted clock after first done, no strobe overlap.
REQ-042 WAIT_EN, zwait_n low 3 T-states on I/O read -> STRB 6 T-states, timeout=0; held low forever, WAIT_MAX=4 -> timeout=1, rdata=8'hFF.
REQ-043 rst asserted mid-STRB -> next clock all strobes=1, zd_oe=0, no done, req_ready=1 after release.

Source files
------------

// File: rtl/zbus_pkg.sv
// zbus_pkg: shared types and constants for the Z80-style bus master.
//   state_e       - bus cycle FSM state encoding
//   req_t         - latched request payload (cycle type, address, write data)
//   MEM_STRB_T    - strobe T-states for a memory cycle
//   IO_STRB_T     - strobe T-states for an I/O cycle (includes the built-in TW)
//   TIMEOUT_RDATA - read data reported when a cycle is aborted on the wait limit
package zbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_STRB = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int unsigned MEM_STRB_T    = 2;
    localparam int unsigned IO_STRB_T     = 3;
    localparam logic [7:0]  TIMEOUT_RDATA = 8'hFF;

    typedef struct packed {
        logic        io;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } req_t;

endpackage

// File: rtl/zbus_tcnt.sv
// zbus_tcnt: T-state prescaler; tick_c marks the last clk of each T-state.
//   clk, rst - clock and synchronous active-high reset
//   clr      - hold the prescaler at the start of a T-state
//   tick_c   - combinational, high on the final clock of the current T-state
module zbus_tcnt #(
    parameter int unsigned TSTATE_CLKS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CW = 4;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_c = (cnt_q == CW'(TSTATE_CLKS - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/zbus_master.sv
// zbus_master: runs one Z80-style memory or I/O bus cycle per accepted request.
//   req_*             - valid/ready request channel (type, address, write data)
//   done/rdata/claimed/timeout - completion pulse and cycle results
//   za, zd_out/zd_oe/zd_in    - address bus and split tristate data bus
//   zmreq_n/ziorq_n/zrd_n/zwr_n - active-low bus strobes
//   ziorqge, zwait_n  - responder claim and wait request
// Optional feature: define ZBUS_MASTER_WAIT_EN to honour zwait_n with a
// WAIT_MAX T-state abort limit; otherwise zwait_n is ignored.
module zbus_master
    import zbus_pkg::*;
#(
    parameter int unsigned TSTATE_CLKS = 2,
    parameter int unsigned WAIT_MAX    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_io,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        claimed,
    output logic        timeout,
    output logic [15:0] za,
    output logic [7:0]  zd_out,
    output logic        zd_oe,
    input  logic [7:0]  zd_in,
    output logic        zmreq_n,
    output logic        ziorq_n,
    output logic        zrd_n,
    output logic        zwr_n,
    input  logic        ziorqge,
    input  logic        zwait_n
);

`ifdef ZBUS_MASTER_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam int unsigned TW = 9;
    localparam int unsigned WW = 8;

    state_e        state_q, state_d;
    logic [TW-1:0] tcount_q, tcount_d;
    logic [WW-1:0] wait_q, wait_d;
    req_t          req_q, req_d;
    logic [7:0]    rdata_stg_q, rdata_stg_d;
    logic          claimed_stg_q, claimed_stg_d;
    logic          timeout_stg_q, timeout_stg_d;
    logic          req_ready_q, req_ready_d;
    logic          done_q, done_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          claimed_q, claimed_d;
    logic          timeout_q, timeout_d;
    logic          zmreq_n_q, zmreq_n_d;
    logic          ziorq_n_q, ziorq_n_d;
    logic          zrd_n_q, zrd_n_d;
    logic          zwr_n_q, zwr_n_d;
    logic          zd_oe_q, zd_oe_d;
    logic          tick_c;
    logic          tclr_c;
    logic [TW-1:0] strb_last_c;

    // Prescaler restarts at each new cycle so ADDR is always a full T-state.
    assign tclr_c = (state_q == ST_IDLE) || (state_q == ST_DONE);

    zbus_tcnt #(.TSTATE_CLKS(TSTATE_CLKS)) u_tcnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (tclr_c),
        .tick_c (tick_c)
    );

    // Index of the final STRB T-state, stretched by inserted wait states.
    assign strb_last_c = (req_q.io ? TW'(IO_STRB_T - 1) : TW'(MEM_STRB_T - 1))
                       + TW'(wait_q);

    // Next-state, request latch and result staging.
    always_comb begin
        state_d       = state_q;
        tcount_d      = tcount_q;
        wait_d        = wait_q;
        req_d         = req_q;
        rdata_stg_d   = rdata_stg_q;
        claimed_stg_d = claimed_stg_q;
        timeout_stg_d = timeout_stg_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d         = '{io: req_io, wr: req_wr, addr: req_addr, wdata: req_wdata};
                    state_d       = ST_ADDR;
                    tcount_d      = '0;
                    wait_d        = '0;
                    timeout_stg_d = 1'b0;
                end
            end
            ST_ADDR: begin
                if (tick_c) begin
                    state_d  = ST_STRB;
                    tcount_d = '0;
                end
            end
            ST_STRB: begin
                if (tick_c) begin
                    if (WAIT_EN && (tcount_q != '0) && !zwait_n) begin
                        if (wait_q == WW'(WAIT_MAX)) begin
                            state_d       = ST_HOLD;
                            tcount_d      = '0;
                            rdata_stg_d   = TIMEOUT_RDATA;
                            claimed_stg_d = req_q.io & ziorqge;
                            timeout_stg_d = 1'b1;
                        end else begin
                            wait_d   = wait_q + WW'(1);
                            tcount_d = tcount_q + TW'(1);
                        end
                    end else if (tcount_q == strb_last_c) begin
                        state_d       = ST_HOLD;
                        tcount_d      = '0;
                        claimed_stg_d = req_q.io & ziorqge;
                        if (!req_q.wr) begin
                            rdata_stg_d = zd_in;
                        end
                    end else begin
                        tcount_d = tcount_q + TW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (tick_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs decoded from the next state so strobes track state exactly.
    always_comb begin
        req_ready_d = (state_d == ST_IDLE);
        done_d      = (state_d == ST_DONE);
        zmreq_n_d   = !((state_d == ST_STRB) && !req_d.io);
        ziorq_n_d   = !((state_d == ST_STRB) &&  req_d.io);
        zrd_n_d     = !((state_d == ST_STRB) && !req_d.wr);
        zwr_n_d     = !((state_d == ST_STRB) &&  req_d.wr);
        zd_oe_d     = req_d.wr && ((state_d == ST_ADDR) || (state_d == ST_STRB)
                                   || (state_d == ST_HOLD));
        rdata_d     = rdata_q;
        claimed_d   = claimed_q;
        timeout_d   = timeout_q;
        // Results publish together with done and stay until the next done.
        if ((state_q == ST_HOLD) && (state_d == ST_DONE)) begin
            rdata_d   = rdata_stg_q;
            claimed_d = claimed_stg_q;
            timeout_d = timeout_stg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            tcount_q      <= '0;
            wait_q        <= '0;
            req_q         <= '0;
            rdata_stg_q   <= '0;
            claimed_stg_q <= 1'b0;
            timeout_stg_q <= 1'b0;
            req_ready_q   <= 1'b1;
            done_q        <= 1'b0;
            rdata_q       <= '0;
            claimed_q     <= 1'b0;
            timeout_q     <= 1'b0;
            zmreq_n_q     <= 1'b1;
            ziorq_n_q     <= 1'b1;
            zrd_n_q       <= 1'b1;
            zwr_n_q       <= 1'b1;
            zd_oe_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            tcount_q      <= tcount_d;
            wait_q        <= wait_d;
            req_q         <= req_d;
            rdata_stg_q   <= rdata_stg_d;
            claimed_stg_q <= claimed_stg_d;
            timeout_stg_q <= timeout_stg_d;
            req_ready_q   <= req_ready_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
            claimed_q     <= claimed_d;
            timeout_q     <= timeout_d;
            zmreq_n_q     <= zmreq_n_d;
            ziorq_n_q     <= ziorq_n_d;
            zrd_n_q       <= zrd_n_d;
            zwr_n_q       <= zwr_n_d;
            zd_oe_q       <= zd_oe_d;
        end
    end

    assign req_ready = req_ready_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign claimed   = claimed_q;
    assign timeout   = timeout_q;
    assign za        = req_q.addr;
    assign zd_out    = req_q.wdata;
    assign zd_oe     = zd_oe_q;
    assign zmreq_n   = zmreq_n_q;
    assign ziorq_n   = ziorq_n_q;
    assign zrd_n     = zrd_n_q;
    assign zwr_n     = zwr_n_q;

endmodule

// File: tb/tb_zbus_master.sv
// tb_zbus_master: directed, table-driven bench for zbus_master (TSTATE_CLKS=2, WAIT_MAX=4).
module tb_zbus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_io = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        done;
    logic [7:0]  rdata;
    logic        claimed;
    logic        timeout;
    logic [15:0] za;
    logic [7:0]  zd_out;
    logic        zd_oe;
    logic [7:0]  zd_in = '0;
    logic        zmreq_n, ziorq_n, zrd_n, zwr_n;
    logic        ziorqge = 1'b0;
    logic        zwait_n = 1'b1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    zbus_master #(.TSTATE_CLKS(2), .WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_io(req_io), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done), .rdata(rdata), .claimed(claimed), .timeout(timeout),
        .za(za), .zd_out(zd_out), .zd_oe(zd_oe), .zd_in(zd_in),
        .zmreq_n(zmreq_n), .ziorq_n(ziorq_n), .zrd_n(zrd_n), .zwr_n(zwr_n),
        .ziorqge(ziorqge), .zwait_n(zwait_n)
    );

    typedef struct {
        logic        io;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  zdin;
        logic        ge;
        int          wait_rel;   // sample index at which zwait_n is released (0: never low)
        logic [7:0]  exp_rdata;
        logic        exp_claimed;
        logic        exp_timeout;
        int          exp_strb;   // clocks with strobes low
        int          exp_lat;    // sample index (1 = first clock after acceptance) of done
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input logic io, input logic wr, input logic [15:0] addr,
                                input logic [7:0] wdata, input logic [7:0] zdin, input logic ge,
                                input int wait_rel, input logic [7:0] exp_rdata,
                                input logic exp_claimed, input logic exp_timeout,
                                input int exp_strb, input int exp_lat);
        vec_t v;
        v.io = io; v.wr = wr; v.addr = addr; v.wdata = wdata; v.zdin = zdin; v.ge = ge;
        v.wait_rel = wait_rel; v.exp_rdata = exp_rdata; v.exp_claimed = exp_claimed;
        v.exp_timeout = exp_timeout; v.exp_strb = exp_strb; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(req_ready), 32'd1);
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int         s;
        int         strb_cnt;
        int         errs;
        bit         seen;
        logic       act;
        logic [3:0] exp_s;
        req_io = v.io; req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata;
        zd_in = v.zdin; ziorqge = v.ge; zwait_n = (v.wait_rel == 0);
        req_valid = 1'b1;
        wait_ready($sformatf("v%0d_ready", idx));
        @(posedge clk); #1;
        // Scramble request inputs: they must not affect the running cycle.
        req_valid = 1'b0; req_io = ~v.io; req_wr = ~v.wr;
        req_addr = ~v.addr; req_wdata = ~v.wdata;
        s = 1; strb_cnt = 0; errs = 0; seen = 0;
        while (s < 60 && !seen) begin
            if (s == v.wait_rel) zwait_n = 1'b1;
            if (done === 1'b1) begin
                seen = 1;
            end else begin
                act   = (s > 2) && (s <= 2 + v.exp_strb);
                exp_s = act ? {v.io, !v.io, v.wr, !v.wr} : 4'hF;
                if ({zmreq_n, ziorq_n, zrd_n, zwr_n} !== exp_s) errs++;
                if (!zmreq_n || !ziorq_n) strb_cnt++;
                if (za !== v.addr || zd_oe !== v.wr || req_ready !== 1'b0) errs++;
                if (v.wr && zd_out !== v.wdata) errs++;
                @(posedge clk); #1;
                s++;
            end
        end
        zwait_n = 1'b1;
        check($sformatf("v%0d_latency", idx), 32'(s), 32'(v.exp_lat));
        check($sformatf("v%0d_strb_clks", idx), 32'(strb_cnt), 32'(v.exp_strb));
        check($sformatf("v%0d_bus_errs", idx), 32'(errs), 32'd0);
        check($sformatf("v%0d_rdata", idx), 32'(rdata), 32'(v.exp_rdata));
        check($sformatf("v%0d_claimed", idx), 32'(claimed), 32'(v.exp_claimed));
        check($sformatf("v%0d_timeout", idx), 32'(timeout), 32'(v.exp_timeout));
        check($sformatf("v%0d_done_bus", idx), 32'({zmreq_n, ziorq_n, zrd_n, zwr_n, zd_oe}), 32'h1E);
        @(posedge clk); #1;
        check($sformatf("v%0d_done_pulse", idx), 32'({done, req_ready}), 32'b01);
    endtask

    initial begin
        int n;
        int dcnt;

        // Memory cycles: 4 strobe clocks, done at 9; I/O: 6 strobe clocks, done at 11.
        vecs[0] = mk(1'b0, 1'b0, 16'h4000, 8'h00, 8'h5A, 1'b0,   0, 8'h5A, 1'b0, 1'b0,  4,  9);
        vecs[1] = mk(1'b1, 1'b1, 16'h80AB, 8'h3C, 8'hEE, 1'b1,   0, 8'h5A, 1'b1, 1'b0,  6, 11);
        vecs[2] = mk(1'b1, 1'b0, 16'h0012, 8'h00, 8'hA7, 1'b0,   0, 8'hA7, 1'b0, 1'b0,  6, 11);
        vecs[3] = mk(1'b0, 1'b1, 16'hFFFF, 8'h00, 8'h11, 1'b1,   0, 8'hA7, 1'b0, 1'b0,  4,  9);
        vecs[4] = mk(1'b1, 1'b0, 16'h00FF, 8'h00, 8'h3C, 1'b1,   0, 8'h3C, 1'b1, 1'b0,  6, 11);
        vecs[5] = mk(1'b0, 1'b0, 16'h0000, 8'h00, 8'hFF, 1'b0,   0, 8'hFF, 1'b0, 1'b0,  4,  9);
`ifdef ZBUS_MASTER_WAIT_EN
        // Three wait T-states stretch STRB to 6 T-states; waiting forever aborts after 4.
        vecs[6] = mk(1'b1, 1'b0, 16'h0042, 8'h00, 8'h66, 1'b0,  11, 8'h66, 1'b0, 1'b0, 12, 17);
        vecs[7] = mk(1'b1, 1'b0, 16'h0043, 8'h00, 8'h99, 1'b0, 100, 8'hFF, 1'b0, 1'b1, 12, 17);
`else
        // zwait_n has no effect: normal I/O timing, never a timeout.
        vecs[6] = mk(1'b1, 1'b0, 16'h0042, 8'h00, 8'h66, 1'b0,  11, 8'h66, 1'b0, 1'b0,  6, 11);
        vecs[7] = mk(1'b1, 1'b0, 16'h0043, 8'h00, 8'hC3, 1'b0, 100, 8'hC3, 1'b0, 1'b0,  6, 11);
`endif
        vecs[8] = mk(1'b0, 1'b0, 16'h2222, 8'h00, 8'h44, 1'b1,   0, 8'h44, 1'b0, 1'b0,  4,  9);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 32'({req_ready, done, claimed, timeout, zd_oe}), 32'b10000);
        check("rst_strobes", 32'({zmreq_n, ziorq_n, zrd_n, zwr_n}), 32'hF);
        check("rst_data", 32'({rdata, zd_out, za}), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_release_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            run_txn(i, vecs[i]);
        end

        // Back-to-back: request held valid is accepted the clock after done.
        req_io = 1'b0; req_wr = 1'b0; req_addr = 16'h1234; req_wdata = 8'h00;
        zd_in = 8'h77; ziorqge = 1'b0; req_valid = 1'b1;
        wait_ready("b2b_ready");
        @(posedge clk); #1;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_first_done", 32'({done, req_ready}), 32'b10);
        check("b2b_first_rdata", 32'(rdata), 32'h77);
        req_wr = 1'b1; req_addr = 16'h5678; req_wdata = 8'h9E; zd_in = 8'h00;
        @(posedge clk); #1;
        check("b2b_gap", 32'({done, req_ready, zmreq_n, ziorq_n, zrd_n, zwr_n}), 32'b011111);
        @(posedge clk); #1;
        check("b2b_second_addr", 32'({req_ready, zmreq_n, ziorq_n, zrd_n, zwr_n, zd_oe}), 32'b011111);
        check("b2b_second_za", 32'(za), 32'h5678);
        req_valid = 1'b0; req_addr = 16'h0000;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_second_latency", 32'(n + 1), 32'd9);
        check("b2b_second_rdata", 32'({rdata, claimed, timeout}), 32'({8'h77, 2'b00}));
        @(posedge clk); #1;

        // Reset in the middle of an I/O write strobe.
        req_io = 1'b1; req_wr = 1'b1; req_addr = 16'h0101; req_wdata = 8'h55;
        ziorqge = 1'b1; req_valid = 1'b1;
        wait_ready("rstmid_ready");
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("rstmid_in_strb", 32'({ziorq_n, zwr_n, zd_oe}), 32'b001);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_strobes", 32'({zmreq_n, ziorq_n, zrd_n, zwr_n}), 32'hF);
        check("rstmid_oe_done", 32'({zd_oe, done}), 32'b00);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rstmid_ready", 32'(req_ready), 32'd1);
        dcnt = 0;
        for (int k = 0; k < 14; k++) begin
            if (done === 1'b1 || zmreq_n !== 1'b1 || ziorq_n !== 1'b1) dcnt++;
            @(posedge clk); #1;
        end
        check("rstmid_no_done", 32'(dcnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
